// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - ALU exception capture FSM with request/ack/eret handshake
module exception_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        EXC_valid,
    input  logic [7:0]  EXC_status,
    input  logic        EXC_check_ovf,
    input  logic        EXC_check_addr,
    input  logic [31:0] EXC_pc,
    input  logic        EXC_ack,
    input  logic        EXC_eret,
    output logic        EXC_req,
    output logic        EXC_stall,
    output logic [3:0]  EXC_cause,
    output logic [31:0] EXC_epc,
    output logic        EXC_busy,
    output logic        EXC_lost,
    output logic [7:0]  EXC_count
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] REQ     = 2'd1;
    localparam logic [1:0] HANDLER = 2'd2;

    localparam logic [3:0] CAUSE_DIV_ZERO = 4'hF;
    localparam logic [3:0] CAUSE_ADDR     = 4'h4;
    localparam logic [3:0] CAUSE_OVF      = 4'hC;

    logic [1:0] state;
    logic       div_zero_hit;
    logic       addr_hit;
    logic       ovf_hit;
    logic       exc_event;
    logic [3:0] event_cause;

    // Status bits 7,5,4,1,0 never participate in event detection.
    assign div_zero_hit = EXC_status[2];
    assign addr_hit     = EXC_status[3] & EXC_check_addr;
    assign ovf_hit      = EXC_status[6] & EXC_check_ovf;
    assign exc_event    = EXC_valid & (div_zero_hit | addr_hit | ovf_hit);

    always_comb begin
        event_cause = CAUSE_OVF;
        if (div_zero_hit) begin
            event_cause = CAUSE_DIV_ZERO;
        end else if (addr_hit) begin
            event_cause = CAUSE_ADDR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            EXC_cause <= 4'h0;
            EXC_epc   <= 32'h0;
            EXC_count <= 8'h00;
            EXC_lost  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (exc_event) begin
                        state     <= REQ;
                        EXC_cause <= event_cause;
                        EXC_epc   <= EXC_pc;
                        if (EXC_count != 8'hFF) begin
                            EXC_count <= EXC_count + 8'd1;
                        end
                    end
                end
                REQ: begin
                    if (exc_event) begin
                        EXC_lost <= 1'b1;
                    end
                    if (EXC_ack) begin
                        state <= HANDLER;
                    end
                end
                HANDLER: begin
                    // An event coinciding with eret is still dropped, not captured.
                    if (exc_event) begin
                        EXC_lost <= 1'b1;
                    end
                    if (EXC_eret) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign EXC_req   = (state == REQ);
    assign EXC_stall = (state == REQ);
    assign EXC_busy  = (state == REQ) | (state == HANDLER);

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - directed self-checking bench for exception_unit
module tb_exception_unit;

    logic        clk;
    logic        reset;
    logic        EXC_valid;
    logic [7:0]  EXC_status;
    logic        EXC_check_ovf;
    logic        EXC_check_addr;
    logic [31:0] EXC_pc;
    logic        EXC_ack;
    logic        EXC_eret;
    logic        EXC_req;
    logic        EXC_stall;
    logic [3:0]  EXC_cause;
    logic [31:0] EXC_epc;
    logic        EXC_busy;
    logic        EXC_lost;
    logic [7:0]  EXC_count;

    int checks;
    int errors;

    exception_unit dut (
        .clk           (clk),
        .reset         (reset),
        .EXC_valid     (EXC_valid),
        .EXC_status    (EXC_status),
        .EXC_check_ovf (EXC_check_ovf),
        .EXC_check_addr(EXC_check_addr),
        .EXC_pc        (EXC_pc),
        .EXC_ack       (EXC_ack),
        .EXC_eret      (EXC_eret),
        .EXC_req       (EXC_req),
        .EXC_stall     (EXC_stall),
        .EXC_cause     (EXC_cause),
        .EXC_epc       (EXC_epc),
        .EXC_busy      (EXC_busy),
        .EXC_lost      (EXC_lost),
        .EXC_count     (EXC_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic capture(input logic [7:0] status, input logic chk_addr,
                           input logic chk_ovf, input logic [31:0] pc);
        EXC_valid      = 1'b1;
        EXC_status     = status;
        EXC_check_addr = chk_addr;
        EXC_check_ovf  = chk_ovf;
        EXC_pc         = pc;
        tick();
        EXC_valid      = 1'b0;
        EXC_status     = 8'h00;
        EXC_check_addr = 1'b0;
        EXC_check_ovf  = 1'b0;
    endtask

    task automatic finish_handler();
        EXC_ack = 1'b1;
        tick();
        EXC_ack = 1'b0;
        EXC_eret = 1'b1;
        tick();
        EXC_eret = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b1;
        EXC_valid = 1'b0;
        EXC_status = 8'h00;
        EXC_check_ovf = 1'b0;
        EXC_check_addr = 1'b0;
        EXC_pc = 32'h0;
        EXC_ack = 1'b0;
        EXC_eret = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_req",   EXC_req,   0);
        check("rst_stall", EXC_stall, 0);
        check("rst_busy",  EXC_busy,  0);
        check("rst_lost",  EXC_lost,  0);
        check("rst_cause", EXC_cause, 0);
        check("rst_epc",   EXC_epc,   0);
        check("rst_count", EXC_count, 0);

        // Overflow trap
        capture(8'h40, 1'b0, 1'b1, 32'h0040_0010);
        check("ovf_req",   EXC_req,   1);
        check("ovf_stall", EXC_stall, 1);
        check("ovf_busy",  EXC_busy,  1);
        check("ovf_cause", EXC_cause, 4'hC);
        check("ovf_epc",   EXC_epc,   32'h0040_0010);
        check("ovf_count", EXC_count, 1);

        // eret in REQ is ignored; ack after 3 REQ cycles
        EXC_eret = 1'b1;
        tick();
        EXC_eret = 1'b0;
        check("eret_in_req", EXC_req, 1);
        tick();
        check("req_hold", EXC_req, 1);
        EXC_ack = 1'b1;
        tick();
        EXC_ack = 1'b0;
        check("ack_req",   EXC_req,   0);
        check("ack_stall", EXC_stall, 0);
        check("ack_busy",  EXC_busy,  1);

        // Event in HANDLER is lost, epc unchanged
        capture(8'h04, 1'b0, 1'b0, 32'h0000_DEAD);
        check("hdl_lost",  EXC_lost,  1);
        check("hdl_epc",   EXC_epc,   32'h0040_0010);
        check("hdl_cause", EXC_cause, 4'hC);
        check("hdl_count", EXC_count, 1);
        check("hdl_req",   EXC_req,   0);

        EXC_eret = 1'b1;
        tick();
        EXC_eret = 1'b0;
        check("eret_busy",  EXC_busy,  0);
        check("eret_cause", EXC_cause, 4'hC);
        check("eret_epc",   EXC_epc,   32'h0040_0010);

        EXC_ack = 1'b1;
        tick();
        EXC_ack = 1'b0;
        check("ack_idle", EXC_busy, 0);

        // Priority
        capture(8'h4C, 1'b1, 1'b1, 32'h0000_0100);
        check("pri_f_cause", EXC_cause, 4'hF);
        check("pri_f_count", EXC_count, 2);
        finish_handler();
        capture(8'h48, 1'b1, 1'b1, 32'h0000_0200);
        check("pri_4_cause", EXC_cause, 4'h4);
        check("pri_4_epc",   EXC_epc,   32'h0000_0200);
        finish_handler();
        check("pri_idle", EXC_busy, 0);

        // Masking
        capture(8'h40, 1'b1, 1'b0, 32'h0000_0300);
        check("mask_ovf_req", EXC_req, 0);
        capture(8'hB3, 1'b1, 1'b1, 32'h0000_0304);
        check("mask_b3_req",   EXC_req,   0);
        check("mask_b3_count", EXC_count, 3);
        EXC_valid = 1'b0;
        EXC_status = 8'h04;
        tick();
        EXC_status = 8'h00;
        check("mask_valid_req", EXC_req, 0);
        check("mask_cause", EXC_cause, 4'h4);

        // eret and event in the same HANDLER cycle
        do_reset();
        check("rst2_lost", EXC_lost, 0);
        capture(8'h04, 1'b0, 1'b0, 32'h0000_0400);
        EXC_ack = 1'b1;
        tick();
        EXC_ack = 1'b0;
        EXC_eret = 1'b1;
        capture(8'h04, 1'b0, 1'b0, 32'h0000_0500);
        EXC_eret = 1'b0;
        check("eret_evt_busy",  EXC_busy,  0);
        check("eret_evt_lost",  EXC_lost,  1);
        check("eret_evt_count", EXC_count, 1);
        check("eret_evt_epc",   EXC_epc,   32'h0000_0400);

        // Reset in REQ together with ack
        capture(8'h40, 1'b0, 1'b1, 32'h0000_0600);
        check("pre_rst_req", EXC_req, 1);
        reset = 1'b1;
        EXC_ack = 1'b1;
        tick();
        reset = 1'b0;
        EXC_ack = 1'b0;
        check("rreq_req",   EXC_req,   0);
        check("rreq_stall", EXC_stall, 0);
        check("rreq_busy",  EXC_busy,  0);
        check("rreq_lost",  EXC_lost,  0);
        check("rreq_cause", EXC_cause, 0);
        check("rreq_epc",   EXC_epc,   0);
        check("rreq_count", EXC_count, 0);
        tick();
        check("rreq_after", EXC_req, 0);

        // Saturation
        for (int i = 0; i < 255; i++) begin
            capture(8'h04, 1'b0, 1'b0, 32'h1000_0000 + i);
            finish_handler();
        end
        check("sat_255", EXC_count, 8'hFF);
        capture(8'h04, 1'b0, 1'b0, 32'h2000_0000);
        check("sat_256_count", EXC_count, 8'hFF);
        check("sat_256_epc",   EXC_epc,   32'h2000_0000);
        finish_handler();
        capture(8'h40, 1'b0, 1'b1, 32'h2000_0004);
        check("sat_257_count", EXC_count, 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
EXCEPTION_UNIT -- requirements
Module: exception_unit

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset: all state updates on the rising edge of clk, and reset is sampled only on that edge.
REQ-002 Port: clk  input  1  system clock.
REQ-003 Port: reset  input  1  synchronous active-high reset.
REQ-004 Port: EXC_valid  input  1  EXC_status/EXC_pc qualify this cycle (one executing instruction).
REQ-005 Port: EXC_status  input  8  ALU status byte {zero, overflow, carry, negative, invalid_address, div_zero, 2'b00}, bit 7 first.
REQ-006 Port: EXC_check_ovf  input  1  current instruction traps on signed overflow (add/sub).
REQ-007 Port: EXC_check_addr  input  1  current instruction is a load/store; address alignment is checked.
REQ-008 Port: EXC_pc  input  32  PC of the current instruction.
REQ-009 Port: EXC_ack  input  1  handler accepts the pending request.
REQ-010 Port: EXC_eret  input  1  return from exception.
REQ-011 Port: EXC_req  output  1  exception request to the fetch/control logic.
REQ-012 Port: EXC_stall  output  1  pipeline hold; equals the REQ-state indicator.
REQ-013 Port: EXC_cause  output  4  cause of the captured exception.
REQ-014 Port: EXC_epc  output  32  PC of the faulting instruction.
REQ-015 Port: EXC_busy  output  1  high in REQ or HANDLER state.
REQ-016 Port: EXC_lost  output  1  sticky: an event occurred while busy.
REQ-017 Port: EXC_count  output  8  saturating count of captured exceptions.

Function
REQ-018 An event SHALL be detected when EXC_valid=1 and at least one of these holds:
- div_zero (bit 2) is set;
- invalid_address (bit 3) and EXC_check_addr are both set;
- overflow (bit 6) and EXC_check_ovf are both set.
REQ-019 Bits 7, 5, 4, 1 and 0 of EXC_status SHALL never cause an event.
REQ-020 Cause priority SHALL be div_zero (4'hF) > address error (4'h4) > overflow (4'hC); only the highest-priority cause is recorded.
REQ-021 FSM states SHALL be IDLE, REQ and HANDLER.
REQ-022 Transition IDLE->REQ SHALL occur on an event at edge N, loading EXC_cause, loading EXC_epc from EXC_pc, and incrementing EXC_count.
REQ-023 EXC_req and EXC_stall SHALL be high from cycle N+1 (one-cycle latency).
REQ-024 REQ SHALL hold EXC_req=1 until EXC_ack=1 is sampled, then move to HANDLER with EXC_req=0 on the next cycle.
REQ-025 HANDLER SHALL hold EXC_busy=1 and EXC_req=0 until EXC_eret=1 is sampled, then return to IDLE.
REQ-026 EXC_cause and EXC_epc SHALL hold their values in REQ and HANDLER, and remain unchanged after return to IDLE until the next capture.
REQ-027 An event in REQ or HANDLER SHALL NOT be captured; it sets EXC_lost=1, which stays set until reset.
REQ-028 EXC_ack in IDLE or HANDLER SHALL be ignored; EXC_eret in IDLE or REQ SHALL be ignored.
REQ-029 EXC_eret and a new event in the same HANDLER cycle: return to IDLE, event counted as lost (EXC_lost=1), not captured.
REQ-030 EXC_count SHALL saturate at 8'hFF; capture at 8'hFF leaves it at 8'hFF.
REQ-031 Events with EXC_valid=0 SHALL be ignored entirely, including for EXC_lost.

Reset
REQ-032 Reset SHALL take priority over all other inputs, including a simultaneous event, EXC_ack or EXC_eret.
REQ-033 Reset SHALL force state IDLE and set EXC_req=0, EXC_stall=0, EXC_busy=0, EXC_lost=0, EXC_cause=4'h0, EXC_epc=32'h0, EXC_count=8'h00, effective from the cycle after the reset edge.
REQ-034 Reset in REQ or HANDLER SHALL abandon the pending exception with no further EXC_req.

Verification
REQ-035 Overflow trap: status 8'h40, EXC_check_ovf=1, pc 32'h0040_0010 -> next cycle EXC_req=1, cause 4'hC, epc 32'h0040_0010, count 1.
REQ-036 Priority: status 8'h4C with both check flags set -> cause 4'hF; repeat with status 8'h48 -> cause 4'h4.
REQ-037 Masking: status 8'h40 with EXC_check_ovf=0 -> no request; status 8'hB3 -> no request, count unchanged.
REQ-038 Handshake: EXC_ack after 3 REQ cycles -> EXC_req drops next cycle; event in HANDLER -> EXC_lost=1, epc unchanged; EXC_eret -> IDLE, busy=0.
REQ-039 Saturation: 256 full capture/ack/eret cycles -> EXC_count=8'hFF and stays there.
REQ-040 Reset in REQ, asserted together with EXC_ack -> all outputs at reset values next cycle, state IDLE.
